mem_ctrl: RTL

//  Owner and sequencer of the single byte-wide synchronous RAM (1-cycle read latency, 2^ADDR_WIDTH bytes).

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial RAM sequencer (mem_ctrl).
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   localparam logic [1:0] LEN_BYTE = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_WORD = 2'b10;

   // Length code 11 is treated as a word.
   function automatic logic [2:0] len_bytes(input logic [1:0] len);
      case (len)
         LEN_BYTE: return 3'd1;
         LEN_HALF: return 3'd2;
         default:  return 3'd4;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] len, input logic [1:0] lsb);
      case (len)
         LEN_BYTE: return 1'b0;
         LEN_HALF: return lsb[0];
         default:  return |lsb;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF and MEM ports onto a byte-wide 1-cycle-latency RAM, little-endian serial bytes.
// Optional MEMCTRL_MISALIGN_TRAP_EN: misaligned MEM half/word accesses ack at once with mem_err_o.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 17,
   parameter int XLEN       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_i,
   input  logic [XLEN-1:0]       if_addr_i,
   output logic                  if_ack_o,
   output logic [XLEN-1:0]       if_data_o,
   input  logic                  mem_req_i,
   input  logic                  mem_we_i,
   input  logic [1:0]            mem_len_i,
   input  logic [XLEN-1:0]       mem_addr_i,
   input  logic [XLEN-1:0]       mem_data_i,
   output logic                  mem_ack_o,
   output logic [XLEN-1:0]       mem_data_o,
   output logic                  mem_err_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [7:0]            ram_data_o,
   input  logic [7:0]            ram_data_i
);

   state_t                state, state_d;
   logic [2:0]            cnt, cnt_d, nb, nb_d, step;
   logic                  owner_mem, owner_mem_d, we, we_d;
   logic [XLEN-1:0]       base, base_d, wdata, wdata_d, asm, asm_d, asm_cap;
   logic [XLEN-1:0]       if_data_d, mem_data_d;
   logic                  ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_d;
   logic [7:0]            ram_data_d;
   logic [1:0]            cap_idx;
   logic                  err, err_d;

   // Byte arriving from RAM this cycle is the one addressed in the previous cycle.
   always_comb begin
      cap_idx = (state == ST_DRAIN) ? cnt[1:0] : cnt[1:0] - 2'd1;
      asm_cap = asm;
      asm_cap[{cap_idx, 3'b000} +: 8] = ram_data_i;
   end

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      nb_d        = nb;
      owner_mem_d = owner_mem;
      we_d        = we;
      base_d      = base;
      wdata_d     = wdata;
      asm_d       = asm;
      if_data_d   = if_data_o;
      mem_data_d  = mem_data_o;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_o;
      ram_data_d  = ram_data_o;
      err_d       = err;
      step        = cnt + 3'd1;
      case (state)
         ST_IDLE: begin
            if (mem_req_i || if_req_i) begin
               owner_mem_d = mem_req_i;
               base_d      = mem_req_i ? mem_addr_i : if_addr_i;
               nb_d        = mem_req_i ? len_bytes(mem_len_i) : 3'd4;
               we_d        = mem_req_i & mem_we_i;
               wdata_d     = mem_req_i ? mem_data_i : '0;
               asm_d       = '0;
               cnt_d       = 3'd0;
               err_d       = 1'b0;
               state_d     = ST_BUSY;
               ram_we_d    = mem_req_i & mem_we_i;
               ram_addr_d  = mem_req_i ? mem_addr_i[ADDR_WIDTH-1:0] : if_addr_i[ADDR_WIDTH-1:0];
               ram_data_d  = mem_req_i ? mem_data_i[7:0] : 8'h00;
`ifdef MEMCTRL_MISALIGN_TRAP_EN
               if (mem_req_i && misaligned(mem_len_i, mem_addr_i[1:0])) begin
                  err_d      = 1'b1;
                  mem_data_d = '0;
                  ram_we_d   = 1'b0;
                  state_d    = ST_ACK;
               end
`endif
            end
         end
         ST_BUSY: begin
            if (!we && cnt != 3'd0) asm_d = asm_cap;
            if (cnt == nb - 3'd1) begin
               state_d = we ? ST_ACK : ST_DRAIN;
            end else begin
               cnt_d      = step;
               ram_we_d   = we;
               ram_addr_d = ADDR_WIDTH'(base + XLEN'(step));
               ram_data_d = wdata[{step[1:0], 3'b000} +: 8];
            end
         end
         ST_DRAIN: begin
            asm_d = asm_cap;
            if (owner_mem) mem_data_d = asm_cap;
            else           if_data_d  = asm_cap;
            state_d = ST_ACK;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         nb         <= '0;
         owner_mem  <= 1'b0;
         we         <= 1'b0;
         base       <= '0;
         wdata      <= '0;
         asm        <= '0;
         if_data_o  <= '0;
         mem_data_o <= '0;
         ram_we_o   <= 1'b0;
         ram_addr_o <= '0;
         ram_data_o <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         nb         <= nb_d;
         owner_mem  <= owner_mem_d;
         we         <= we_d;
         base       <= base_d;
         wdata      <= wdata_d;
         asm        <= asm_d;
         if_data_o  <= if_data_d;
         mem_data_o <= mem_data_d;
         ram_we_o   <= ram_we_d;
         ram_addr_o <= ram_addr_d;
         ram_data_o <= ram_data_d;
         err        <= err_d;
      end
   end

   assign if_ack_o  = (state == ST_ACK) && !owner_mem;
   assign mem_ack_o = (state == ST_ACK) && owner_mem;
`ifdef MEMCTRL_MISALIGN_TRAP_EN
   assign mem_err_o = mem_ack_o & err;
`else
   assign mem_err_o = 1'b0;
`endif

endmodule
